// File: rtl/sram_sp_bwe_init.sv
// Single-port synchronous SRAM model with per-bit write mask, 1- or 2-cycle
// read latency with a valid strobe, and a reset-triggered init sweep.
module sram_sp_bwe_init #(
    parameter int              BITS      = 80,
    parameter int              DEPTH     = 256,
    parameter int              ADD_WIDTH = 8,
    parameter int              READ_LAT  = 1,
    parameter logic [BITS-1:0] INIT_VAL  = '0
) (
    input  logic                 CLK,
    input  logic                 RSTB,
    input  logic                 CEB,
    input  logic                 WEB,
    input  logic [ADD_WIDTH-1:0] A,
    input  logic [BITS-1:0]      D,
    input  logic [BITS-1:0]      BWEB,
    output logic [BITS-1:0]      Q,
    output logic                 QV,
    output logic                 READY,
    output logic                 ADDR_ERR
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [ADD_WIDTH-1:0] LAST    = ADD_WIDTH'(DEPTH - 1);
    localparam logic [ADD_WIDTH:0]   DEPTH_W = (ADD_WIDTH + 1)'(DEPTH);

    state_t               state;
    logic [ADD_WIDTH-1:0] cnt;
    logic [BITS-1:0]      ram [DEPTH];

    logic            access;
    logic            in_range;
    logic            do_write;
    logic            issue;
    logic [BITS-1:0] rd_data;

    // Out-of-range reads still issue into the pipeline, carrying zeros.
    always_comb begin
        access   = (state == RUN) && !CEB;
        in_range = {1'b0, A} < DEPTH_W;
        do_write = access && !WEB && in_range;
        issue    = access && WEB;
        rd_data  = in_range ? ram[A] : '0;
    end

    // NOTE: the array has no reset branch; the init sweep defines its contents
    // and a reset here would block RAM inference.
    always_ff @(posedge CLK) begin
        if (state == INIT) begin
            ram[cnt] <= INIT_VAL;
        end else if (do_write) begin
            ram[A] <= (ram[A] & BWEB) | (D & ~BWEB);
        end
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state    <= INIT;
            cnt      <= '0;
            READY    <= 1'b0;
            ADDR_ERR <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= RUN;
                        cnt   <= '0;
                        READY <= 1'b1;
                    end
                end
                RUN: begin
                    if (access && !in_range) ADDR_ERR <= 1'b1;
                end
                default: state <= INIT;
            endcase
        end
    end

    // Q only moves on a valid result, so it holds the last read otherwise.
    generate
        if (READ_LAT == 1) begin : g_lat1
            always_ff @(posedge CLK or negedge RSTB) begin
                if (!RSTB) begin
                    Q  <= '0;
                    QV <= 1'b0;
                end else begin
                    QV <= issue;
                    if (issue) Q <= rd_data;
                end
            end
        end else begin : g_lat2
            logic            p_valid;
            logic [BITS-1:0] p_data;

            always_ff @(posedge CLK or negedge RSTB) begin
                if (!RSTB) begin
                    p_valid <= 1'b0;
                    p_data  <= '0;
                    Q       <= '0;
                    QV      <= 1'b0;
                end else begin
                    p_valid <= issue;
                    if (issue) p_data <= rd_data;
                    QV <= p_valid;
                    if (p_valid) Q <= p_data;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sram_sp_bwe_init.sv
// Bench for sram_sp_bwe_init: a default instance and a DEPTH=200/READ_LAT=2
// instance share one stimulus stream and are checked against a memory model.
module tb_sram_sp_bwe_init;

    localparam int NI = 2;
    localparam logic [79:0] INIT1 = 80'h5A5A_C3C3_0F0F_9696_1234;

    logic        clk;
    logic        rstb, ceb, web;
    logic [7:0]  a;
    logic [79:0] d, bweb;
    logic [79:0] q0, q1;
    logic        qv0, qv1, ready0, ready1, err0, err1;

    int n_cmp = 0;
    int n_bad = 0;

    sram_sp_bwe_init u_dut0 (
        .CLK(clk), .RSTB(rstb), .CEB(ceb), .WEB(web), .A(a), .D(d), .BWEB(bweb),
        .Q(q0), .QV(qv0), .READY(ready0), .ADDR_ERR(err0)
    );

    sram_sp_bwe_init #(.DEPTH(200), .READ_LAT(2), .INIT_VAL(INIT1)) u_dut1 (
        .CLK(clk), .RSTB(rstb), .CEB(ceb), .WEB(web), .A(a), .D(d), .BWEB(bweb),
        .Q(q1), .QV(qv1), .READY(ready1), .ADDR_ERR(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: word array, edges since reset release, and a queue of
    // read results tagged with the edge at which they become visible.
    typedef struct {
        longint      due;
        logic [79:0] data;
    } rd_t;

    int          depth_m [NI] = '{256, 200};
    int          lat_m   [NI] = '{1, 2};
    logic [79:0] init_m  [NI] = '{80'h0, INIT1};
    logic [79:0] mem     [NI][256];
    int          edges   [NI];
    logic [79:0] q_m     [NI];
    logic        qv_m    [NI];
    logic        err_m   [NI];
    rd_t         pend    [NI][$];
    longint      edge_no = 0;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic        rdy;
        logic [79:0] rd;
        edge_no++;
        if (rstb) begin
            for (int i = 0; i < NI; i++) begin
                rdy     = edges[i] >= depth_m[i];
                qv_m[i] = 1'b0;
                if (rdy && !ceb) begin
                    rd = '0;
                    if (int'(a) < depth_m[i]) begin
                        if (!web) mem[i][a] = (mem[i][a] & bweb) | (d & ~bweb);
                        else      rd = mem[i][a];
                    end else begin
                        err_m[i] = 1'b1;
                    end
                    if (web) pend[i].push_back('{due: edge_no + lat_m[i] - 1, data: rd});
                end
                if (pend[i].size() > 0 && pend[i][0].due == edge_no) begin
                    q_m[i]  = pend[i][0].data;
                    qv_m[i] = 1'b1;
                    void'(pend[i].pop_front());
                end
                if (!rdy) begin
                    edges[i]++;
                    if (edges[i] == depth_m[i])
                        for (int j = 0; j < depth_m[i]; j++) mem[i][j] = init_m[i];
                end
            end
        end
    endtask

    task automatic compare_all();
        check($sformatf("q[0]@%0d", edge_no), q0, q_m[0]);
        check($sformatf("qv[0]@%0d", edge_no), 80'(qv0), 80'(qv_m[0]));
        check($sformatf("ready[0]@%0d", edge_no), 80'(ready0), 80'(edges[0] >= depth_m[0]));
        check($sformatf("err[0]@%0d", edge_no), 80'(err0), 80'(err_m[0]));
        check($sformatf("q[1]@%0d", edge_no), q1, q_m[1]);
        check($sformatf("qv[1]@%0d", edge_no), 80'(qv1), 80'(qv_m[1]));
        check($sformatf("ready[1]@%0d", edge_no), 80'(ready1), 80'(edges[1] >= depth_m[1]));
        check($sformatf("err[1]@%0d", edge_no), 80'(err1), 80'(err_m[1]));
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_edge();
        compare_all();
    endtask

    task automatic drive(input logic c, input logic w, input logic [7:0] ad,
                         input logic [79:0] dd, input logic [79:0] bw);
        ceb  = c;
        web  = w;
        a    = ad;
        d    = dd;
        bweb = bw;
    endtask

    task automatic apply_reset();
        rstb = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            q_m[i]   = '0;
            qv_m[i]  = 1'b0;
            err_m[i] = 1'b0;
            edges[i] = 0;
            pend[i].delete();
        end
        compare_all();
        cycle();
        cycle();
        rstb = 1'b1;
    endtask

    // Counts edges from reset release until each READY is seen high (bounded).
    task automatic sweep(output int n0, output int n1);
        n0 = -1;
        n1 = -1;
        for (int i = 1; i <= 600 && (n0 < 0 || n1 < 0); i++) begin
            cycle();
            if (n0 < 0 && ready0) n0 = i;
            if (n1 < 0 && ready1) n1 = i;
        end
    endtask

    initial begin
        int          n0, n1;
        logic [79:0] mask;

        rstb = 1'b1;
        drive(1'b1, 1'b1, 8'h00, '0, '1);
        #2;
        apply_reset();

        // Init sweep with a read held on A=0 throughout.
        drive(1'b0, 1'b1, 8'h00, '0, '1);
        sweep(n0, n1);
        check("sweep_len0", 80'(n0), 80'd256);
        check("sweep_len1", 80'(n1), 80'd200);
        cycle();
        check("first_read_qv", 80'(qv0), 80'd1);
        check("first_read_q", q0, 80'd0);
        drive(1'b1, 1'b1, 8'h00, '0, '1);
        cycle();
        check("first_read_qv_drop", 80'(qv0), 80'd0);
        cycle();

        // Bit-mask write.
        mask = '0;
        mask[0] = 1'b1;
        mask[47:40] = 8'hFF;
        mask[79] = 1'b1;
        drive(1'b0, 1'b0, 8'h05, '1, ~mask);
        cycle();
        drive(1'b0, 1'b1, 8'h05, '0, '1);
        cycle();
        check("bitmask_q0", q0, mask);
        drive(1'b1, 1'b1, 8'h00, '0, '1);
        cycle();
        check("bitmask_q1", q1, INIT1 | mask);

        // Back-to-back reads.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b0, 8'(i), 80'(i), '0);
            cycle();
        end
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b1, 8'(i), '0, '1);
            cycle();
            check($sformatf("b2b_q0_%0d", i), q0, 80'(i));
            if (i > 1) check($sformatf("b2b_q1_%0d", i), q1, 80'(i - 1));
        end
        drive(1'b1, 1'b1, 8'h00, '0, '1);
        cycle();
        check("b2b_last_q1", q1, 80'd4);
        check("b2b_last_qv1", 80'(qv1), 80'd1);
        cycle();
        check("b2b_hold_q1", q1, 80'd4);
        check("b2b_hold_qv1", 80'(qv1), 80'd0);

        // Out-of-range accesses on the 200-word instance.
        drive(1'b0, 1'b0, 8'd210, '1, '0);
        cycle();
        check("oor_err1", 80'(err1), 80'd1);
        check("oor_err0", 80'(err0), 80'd0);
        drive(1'b0, 1'b1, 8'd210, '0, '1);
        cycle();
        drive(1'b0, 1'b1, 8'd199, '0, '1);
        cycle();
        check("oor_read_q1", q1, 80'd0);
        check("oor_read_qv1", 80'(qv1), 80'd1);
        drive(1'b1, 1'b1, 8'h00, '0, '1);
        cycle();
        check("in_range_199_q1", q1, INIT1);

        // Write then read the same address, then hold with CEB high.
        drive(1'b0, 1'b0, 8'h10, 80'hABCD, '0);
        cycle();
        drive(1'b0, 1'b1, 8'h10, '0, '1);
        cycle();
        check("wr_rd_q0", q0, 80'hABCD);
        drive(1'b1, 1'b1, 8'h00, '0, '1);
        for (int i = 0; i < 10; i++) cycle();
        check("hold_q0", q0, 80'hABCD);
        check("hold_q1", q1, 80'hABCD);
        check("hold_qv0", 80'(qv0), 80'd0);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)),
                  {16'($urandom), $urandom, $urandom},
                  {16'($urandom), $urandom, $urandom});
            cycle();
        end

        // Reset during an in-flight two-cycle read.
        drive(1'b0, 1'b0, 8'h20, 80'hFEED_BEEF, '0);
        cycle();
        drive(1'b0, 1'b1, 8'h20, '0, '1);
        cycle();
        check("pre_reset_q0", q0, 80'hFEED_BEEF);
        drive(1'b1, 1'b1, 8'h00, '0, '1);
        apply_reset();
        check("rst_q1", q1, 80'd0);
        check("rst_qv1", 80'(qv1), 80'd0);
        check("rst_err1", 80'(err1), 80'd0);
        sweep(n0, n1);
        check("resweep_len0", 80'(n0), 80'd256);
        check("resweep_len1", 80'(n1), 80'd200);

        // Reset at sweep address 100.
        apply_reset();
        for (int i = 0; i < 100; i++) cycle();
        apply_reset();
        drive(1'b0, 1'b1, 8'h20, '0, '1);
        sweep(n0, n1);
        check("midsweep_len0", 80'(n0), 80'd256);
        check("midsweep_len1", 80'(n1), 80'd200);
        cycle();
        check("after_resweep_q0", q0, 80'd0);
        drive(1'b1, 1'b1, 8'h00, '0, '1);
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
